// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receive frame controller: state encoding,
// legal prescale ratios and counter widths.
package uart_rx_pkg;

    localparam int unsigned DATA_W_DFLT  = 8;
    localparam int unsigned PRESC_W_DFLT = 6;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned EDGE_W  = 5;
    localparam int unsigned BIT_W   = 4;
    localparam int unsigned PR_W    = 6;

    localparam int unsigned PRESC_8  = 8;
    localparam int unsigned PRESC_16 = 16;
    localparam int unsigned PRESC_32 = 32;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter and frame bit counter; flags the last edge of
// every bit for the latched prescale ratio.
module uart_rx_edge_bit_cnt
    import uart_rx_pkg::*;
(
    input  logic              clk,
    input  logic              rest,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic [PR_W-1:0]   pr_i,
    output logic [EDGE_W-1:0] edge_cnt_o,
    output logic [BIT_W-1:0]  bit_cnt_o,
    output logic              last_edge_o
);

    logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              last_edge_c;

    assign last_edge_c = en_i && (edge_cnt_q == EDGE_W'(pr_i - PR_W'(1)));

    always_comb begin
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        if (clr_i) begin
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
        end else if (en_i) begin
            if (last_edge_c) begin
                edge_cnt_d = '0;
                bit_cnt_d  = bit_cnt_q + BIT_W'(1);
            end else begin
                edge_cnt_d = edge_cnt_q + EDGE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign edge_cnt_o  = edge_cnt_q;
    assign bit_cnt_o   = bit_cnt_q;
    assign last_edge_o = last_edge_c;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detection, bit timing, parity and
// stop checking, and the one-cycle data_valid strobe for clean frames.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DFLT,
    parameter int unsigned PRESC_W = PRESC_W_DFLT
) (
    input  logic               clk,
    input  logic               rest,
    input  logic               rx_in,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               par_en,
    input  logic               par_typ,
    input  logic               sampled_bit,
    output logic [EDGE_W-1:0]  edge_cnt,
    output logic [BIT_W-1:0]   bit_cnt,
    output logic               dat_samp_en,
    output logic               deslz_en,
    output logic               par_err,
    output logic               stp_err,
    output logic               data_valid
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [PR_W-1:0]    pr_q, pr_d, pr_sel_c;
    logic               acc_q, acc_d;
    logic               par_err_q, par_err_d;
    logic               stp_err_q, stp_err_d;
    logic               dv_q, dv_d;
    logic               last_edge_c;
    logic               cnt_clr_c;
    logic [BIT_W-1:0]   bit_cnt_w;

    // Illegal ratios fall back to 8x oversampling.
    always_comb begin
        pr_sel_c = PR_W'(PRESC_8);
        if (prescale == PRESC_W'(PRESC_16)) begin
            pr_sel_c = PR_W'(PRESC_16);
        end else if (prescale == PRESC_W'(PRESC_32)) begin
            pr_sel_c = PR_W'(PRESC_32);
        end
    end

    assign dat_samp_en = (state_q == START) || (state_q == DATA) ||
                         (state_q == PARITY) || (state_q == STOP);
    assign cnt_clr_c   = (state_q == IDLE) || (state_q == DONE);
    assign deslz_en    = (state_q == DATA) && last_edge_c;

    uart_rx_edge_bit_cnt u_cnt (
        .clk         (clk),
        .rest        (rest),
        .en_i        (dat_samp_en),
        .clr_i       (cnt_clr_c),
        .pr_i        (pr_q),
        .edge_cnt_o  (edge_cnt),
        .bit_cnt_o   (bit_cnt_w),
        .last_edge_o (last_edge_c)
    );

    assign bit_cnt = bit_cnt_w;

    always_comb begin
        state_d   = state_q;
        pr_d      = pr_q;
        acc_d     = acc_q;
        par_err_d = par_err_q;
        stp_err_d = stp_err_q;
        dv_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_in) begin
                    state_d   = START;
                    pr_d      = pr_sel_c;
                    par_err_d = 1'b0;
                    stp_err_d = 1'b0;
                end
            end
            START: begin
                if (last_edge_c) begin
                    state_d = sampled_bit ? IDLE : DATA;
                end
            end
            DATA: begin
                if (last_edge_c) begin
                    acc_d = acc_q ^ sampled_bit;
                    if (bit_cnt_w == BIT_W'(DATA_W)) begin
                        state_d = par_en ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (last_edge_c) begin
                    par_err_d = ((acc_q ^ par_typ) != sampled_bit);
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (last_edge_c) begin
                    stp_err_d = ~sampled_bit;
                    dv_d      = sampled_bit & ~par_err_q;
                    state_d   = DONE;
                end
            end
            DONE: begin
                // A low line here is the next frame's start bit.
                acc_d = 1'b0;
                if (!rx_in) begin
                    state_d   = START;
                    par_err_d = 1'b0;
                    stp_err_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            state_q   <= IDLE;
            pr_q      <= PR_W'(PRESC_8);
            acc_q     <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
            dv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pr_q      <= pr_d;
            acc_q     <= acc_d;
            par_err_q <= par_err_d;
            stp_err_q <= stp_err_d;
            dv_q      <= dv_d;
        end
    end

    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;
    assign data_valid = dv_q;

endmodule
